key_expansion: RTL and testbench

KEY_EXPANSION -- requirements
Module: key_expansion

---
 rtl/aes_pkg.sv | 29 ++
 rtl/key_expansion_if.sv | 24 ++
 rtl/aes_sbox.sv | 40 ++++
 rtl/key_expansion.sv | 94 +++++++++
 tb/tb_key_expansion.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round count, Rcon table and the block type.
package aes_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [0:127] block_t;

    localparam int NK = 4;
    localparam int NR = 10;

    localparam logic [7:0] RCON [1:NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Indices outside 1..NR contribute nothing to the key word.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        if (r >= 4'd1 && r <= 4'(NR)) begin
            v = RCON[r];
        end
        return v;
    endfunction

endpackage

// File: rtl/key_expansion_if.sv
// Request/round-key stream between the key schedule and its consumer.
interface key_expansion_if;
    import aes_pkg::*;

    logic       start;
    block_t     key_in;
    logic       key_ready;
    block_t     round_key;
    logic [3:0] round_idx;
    logic       key_valid;
    logic       busy;
    logic       done;

    modport slave (
        input  start, key_in, key_ready,
        output round_key, round_idx, key_valid, busy, done
    );

    modport master (
        output start, key_in, key_ready,
        input  round_key, round_idx, key_valid, busy, done
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the inverse for a != 0 and yields 0 for a == 0, as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign s_o = affine(gf_inv(a_i));

endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule: streams round keys 0..10 one per accepted transfer.
module key_expansion
    import aes_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    key_expansion_if.slave  bus
);

    state_t     state_q, state_d;
    block_t     rk_q, rk_d;
    logic [3:0] idx_q, idx_d;
    logic       vld_q, vld_d;
    logic       done_q, done_d;

    logic [0:31] w0, w1, w2, w3;
    logic [0:31] rot_w, sub_w, temp_w;
    logic [0:31] nw0, nw1, nw2, nw3;

    assign w0 = rk_q[0:31];
    assign w1 = rk_q[32:63];
    assign w2 = rk_q[64:95];
    assign w3 = rk_q[96:127];

    assign rot_w = {w3[8:31], w3[0:7]};

    for (genvar g = 0; g < NK; g++) begin : g_subword
        aes_sbox u_sbox (
            .a_i (rot_w[8*g +: 8]),
            .s_o (sub_w[8*g +: 8])
        );
    end

    assign temp_w = sub_w ^ {rcon_of(idx_q + 4'd1), 24'h000000};
    assign nw0    = w0 ^ temp_w;
    assign nw1    = w1 ^ nw0;
    assign nw2    = w2 ^ nw1;
    assign nw3    = w3 ^ nw2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rk_q    <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rk_d    = bus.key_in;
                    idx_d   = 4'd0;
                    vld_d   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Everything holds while the consumer stalls.
                if (vld_q && bus.key_ready) begin
                    if (idx_q == 4'(NR)) begin
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rk_d  = {nw0, nw1, nw2, nw3};
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.round_key = rk_q;
    assign bus.round_idx = idx_q;
    assign bus.key_valid = vld_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_key_expansion.sv
// Directed bench for the AES-128 key schedule against FIPS-197 round-key vectors.
module tb_key_expansion;
    import aes_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    key_expansion_if bus ();

    key_expansion dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    block_t exp_rk    [0:10];
    bit     exp_known [0:10];

    localparam block_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam block_t ZERO_KEY = 128'h0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load_fips();
        exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i <= 10; i++) exp_known[i] = 1'b1;
    endtask

    task automatic load_zero();
        for (int i = 0; i <= 10; i++) begin
            exp_rk[i]    = '0;
            exp_known[i] = 1'b0;
        end
        exp_rk[0]     = 128'h0;
        exp_rk[1]     = 128'h62636363626363636263636362636363;
        exp_rk[10]    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        exp_known[0]  = 1'b1;
        exp_known[1]  = 1'b1;
        exp_known[10] = 1'b1;
    endtask

    // Ends on the falling edge right after the accepting start edge.
    task automatic start_exp(input block_t key);
        @(negedge clk);
        bus.key_in = key;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.key_in = ~key;
    endtask

    task automatic monitor(input string tag, input bit rand_rdy, input int poke_idx,
                           input bit do_chain, input block_t chain_key);
        int         n;
        int         cyc;
        bit         pv;
        bit         pr;
        bit         rdy;
        block_t     prk;
        logic [3:0] pidx;
        n    = 0;
        cyc  = 1;
        pv   = 1'b0;
        pr   = 1'b0;
        prk  = '0;
        pidx = '0;
        while (n < 11 && cyc < 300) begin
            if (pv && !pr) begin
                check_val({tag, " stall_key"}, bus.round_key, prk);
                check_val({tag, " stall_idx"}, 128'(bus.round_idx), 128'(pidx));
                check_val({tag, " stall_vld"}, 128'(bus.key_valid), 128'd1);
            end
            if (bus.key_valid && bus.round_idx == 4'd5) begin
                check_val({tag, " busy"}, 128'(bus.busy), 128'd1);
            end
            rdy           = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.key_ready = rdy;
            if (poke_idx >= 0 && bus.key_valid && int'(bus.round_idx) == poke_idx) begin
                bus.start  = 1'b1;
                bus.key_in = 128'hdeadbeef0123456789abcdeffedcba98;
            end else begin
                bus.start  = 1'b0;
            end
            if (bus.key_valid && rdy) begin
                check_val({tag, " idx"}, 128'(bus.round_idx), 128'(n));
                if (exp_known[n]) begin
                    check_val($sformatf("%s rk%0d", tag, n), bus.round_key, exp_rk[n]);
                end
                if (!rand_rdy && n == 10) begin
                    check_val({tag, " latency"}, 128'(cyc), 128'd11);
                end
                n++;
            end
            pv   = bus.key_valid;
            pr   = rdy;
            prk  = bus.round_key;
            pidx = bus.round_idx;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check_val({tag, " xfers"}, 128'(n), 128'd11);
        check_val({tag, " done_pulse"}, 128'(bus.done), 128'd1);
        check_val({tag, " vld_clr"}, 128'(bus.key_valid), 128'd0);
        check_val({tag, " busy_clr"}, 128'(bus.busy), 128'd0);
        check_val({tag, " idx_keep"}, 128'(bus.round_idx), 128'd10);
        check_val({tag, " rk_keep"}, bus.round_key, exp_rk[10]);
        bus.key_ready = 1'b0;
        if (do_chain) begin
            bus.key_in = chain_key;
            bus.start  = 1'b1;
        end
        @(negedge clk);
        bus.start  = 1'b0;
        bus.key_in = ~chain_key;
        check_val({tag, " done_once"}, 128'(bus.done), 128'd0);
        if (do_chain) begin
            check_val({tag, " chain_vld"}, 128'(bus.key_valid), 128'd1);
            check_val({tag, " chain_idx"}, 128'(bus.round_idx), 128'd0);
            check_val({tag, " chain_rk0"}, bus.round_key, chain_key);
        end else begin
            check_val({tag, " idle_rk"}, bus.round_key, exp_rk[10]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.key_in    = '0;
        bus.key_ready = 1'b0;
        #1;
        check_val("rst_vld", 128'(bus.key_valid), 128'd0);
        check_val("rst_busy", 128'(bus.busy), 128'd0);
        check_val("rst_done", 128'(bus.done), 128'd0);
        check_val("rst_rk", bus.round_key, 128'd0);
        check_val("rst_idx", 128'(bus.round_idx), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        load_fips();
        start_exp(FIPS_KEY);
        monitor("fips", 1'b0, -1, 1'b0, FIPS_KEY);

        start_exp(FIPS_KEY);
        monitor("stall", 1'b1, 3, 1'b1, ZERO_KEY);
        load_zero();
        monitor("zero", 1'b0, -1, 1'b0, ZERO_KEY);

        load_fips();
        start_exp(FIPS_KEY);
        bus.key_ready = 1'b1;
        k = 0;
        while (!(bus.key_valid && bus.round_idx == 4'd5) && k < 30) begin
            @(negedge clk);
            k++;
        end
        check_val("mid_idx", 128'(bus.round_idx), 128'd5);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_vld", 128'(bus.key_valid), 128'd0);
        check_val("mid_rst_busy", 128'(bus.busy), 128'd0);
        check_val("mid_rst_rk", bus.round_key, 128'd0);
        check_val("mid_rst_idx", 128'(bus.round_idx), 128'd0);
        bus.key_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start_exp(FIPS_KEY);
        monitor("after_rst", 1'b0, -1, 1'b0, FIPS_KEY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
